// File: rtl/data_link_pkg.sv
// Purpose : constants and state type shared by the host-link byte paths (rx and tx).
// Latency : n/a (package only).
// Backpressure: n/a; word/byte widths and default idle timeout live here.
package data_link_pkg;

    localparam int BYTES_PER_WORD     = 4;
    localparam int WORD_W             = 32;
    localparam int BYTE_W             = 8;
    localparam int TIMEOUT_CYCLES_DEF = 1_000_000;

    // Width of the byte-within-word counter.
    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_WRITE   = 1'b1
    } link_state_t;

endpackage

// File: rtl/data_rx_packer_if.sv
// Purpose : UART-byte-in / FIFO-word-out bundle of the receive packer, plus sticky error flags.
// Latency : n/a (signal bundle only).
// Backpressure: FIFOFull from the consumer stalls FIFOWrite; UART side has no ready.
interface data_rx_packer_if;
    import data_link_pkg::*;

    logic [BYTE_W-1:0] UARTData;
    logic              UARTDataValid;
    logic              FIFOFull;
    logic              ClearErrors;
    logic [WORD_W-1:0] FIFOData;
    logic              FIFOWrite;
    logic              Busy;
    logic              Overflow;
    logic              Timeout;

    // Packer side.
    modport slave (
        input  UARTData, UARTDataValid, FIFOFull, ClearErrors,
        output FIFOData, FIFOWrite, Busy, Overflow, Timeout
    );

    // Byte source / FIFO / control side.
    modport master (
        output UARTData, UARTDataValid, FIFOFull, ClearErrors,
        input  FIFOData, FIFOWrite, Busy, Overflow, Timeout
    );
endinterface

// File: rtl/data_rx_packer_idle_timer.sv
// Purpose : idle-cycle counter; pulses expired_o on the TIMEOUT_CYCLES-th consecutive enabled cycle.
// Latency : expired_o is combinational from the count register and en_i/clr_i.
// Backpressure: none; clr_i has priority and suppresses expiry in the same cycle.
// Ports: clk_i, rst_n_i (async active-low), en_i (count this cycle), clr_i (restart), expired_o (pulse).
module rx_idle_timer
    import data_link_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic clr_i,
    output logic expired_o
);
    localparam int             W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0]   LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // The edge that closes the TIMEOUT_CYCLES-th idle cycle is the expiry edge.
    assign expired_o = en_i && !clr_i && (cnt_q >= LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || expired_o) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q < LAST)) begin
            cnt_d = cnt_q + 1'b1;   // saturating, never wraps
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/data_rx_packer.sv
// Purpose : packs UART bytes MSB-first into 32-bit words and writes them to the command FIFO.
// Latency : FIFOWrite rises the cycle after the 4th byte edge when the FIFO is not full.
// Backpressure: FIFOFull holds the word in WRITE; bytes arriving then are dropped (Overflow).
// Ports: Clk, ResetN (async active-low), link (slave modport: UART byte in, FIFO word out, flags).
module data_rx_packer
    import data_link_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic           Clk,
    input  logic           ResetN,
    data_rx_packer_if.slave link
);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

    link_state_t       state_q;
    logic [WORD_W-1:0] shift_q;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;
    logic              timeout_q;

    logic wr_en;
    logic tmr_en;
    logic tmr_clr;
    logic tmr_exp;

    assign wr_en   = (state_q == ST_WRITE) && !link.FIFOFull;
    assign tmr_en  = (state_q == ST_COLLECT) && (count_q != '0);
    // A byte landing on the expiry edge clears the timer, so the byte wins.
    assign tmr_clr = ((state_q == ST_COLLECT) && link.UARTDataValid) || (count_q == '0);

    rx_idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk_i     (Clk),
        .rst_n_i   (ResetN),
        .en_i      (tmr_en),
        .clr_i     (tmr_clr),
        .expired_o (tmr_exp)
    );

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q    <= ST_COLLECT;
            shift_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (link.UARTDataValid) begin
                        shift_q <= {shift_q[WORD_W-BYTE_W-1:0], link.UARTData};
                        if (count_q == LAST_BYTE) begin
                            count_q <= '0;
                            state_q <= ST_WRITE;
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end else if (tmr_exp) begin
                        count_q <= '0;
                        shift_q <= '0;
                    end
                end
                ST_WRITE: begin
                    if (!link.FIFOFull) begin
                        state_q <= ST_COLLECT;
                        // The FIFO samples the old word this cycle, so the new
                        // byte can start the next word in the same edge.
                        if (link.UARTDataValid) begin
                            shift_q <= {shift_q[WORD_W-BYTE_W-1:0], link.UARTData};
                            count_q <= CNT_W'(1);
                        end
                    end
                end
                default: state_q <= ST_COLLECT;
            endcase

            // Set beats clear when both happen on the same edge.
            if ((state_q == ST_WRITE) && link.UARTDataValid && link.FIFOFull) begin
                overflow_q <= 1'b1;
            end else if (link.ClearErrors) begin
                overflow_q <= 1'b0;
            end

            if (tmr_exp) begin
                timeout_q <= 1'b1;
            end else if (link.ClearErrors) begin
                timeout_q <= 1'b0;
            end
        end
    end

    assign link.FIFOData  = shift_q;
    assign link.FIFOWrite = wr_en;
    assign link.Busy      = (count_q != '0) || (state_q == ST_WRITE);
    assign link.Overflow  = overflow_q;
    assign link.Timeout   = timeout_q;
endmodule

// File: tb/tb_data_rx_packer.sv
// Purpose : directed checks of data_rx_packer: packing, FIFO stall, overflow, idle timeout, reset.
// Latency : inputs driven 1ns after the rising edge, outputs checked there too.
// Backpressure: FIFOFull driven directly; two DUTs share stimulus, one with a short timeout.
module tb_data_rx_packer;

    logic        Clk = 1'b0;
    logic        ResetN = 1'b0;
    logic [7:0]  udata = 8'h00;
    logic        uvld = 1'b0;
    logic        ffull = 1'b0;
    logic        clr_err = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_a     = 0;
    int wr_b     = 0;
    int snap;

    always #5 Clk = ~Clk;

    data_rx_packer_if bus_a ();
    data_rx_packer_if bus_b ();

    assign bus_a.UARTData      = udata;
    assign bus_a.UARTDataValid = uvld;
    assign bus_a.FIFOFull      = ffull;
    assign bus_a.ClearErrors   = clr_err;
    assign bus_b.UARTData      = udata;
    assign bus_b.UARTDataValid = uvld;
    assign bus_b.FIFOFull      = ffull;
    assign bus_b.ClearErrors   = clr_err;

    // Long-timeout instance for packing/stall tests.
    data_rx_packer u_dut (
        .Clk    (Clk),
        .ResetN (ResetN),
        .link   (bus_a.slave)
    );

    // Short-timeout instance for the idle-timeout tests.
    data_rx_packer #(.TIMEOUT_CYCLES(20)) u_dut_t (
        .Clk    (Clk),
        .ResetN (ResetN),
        .link   (bus_b.slave)
    );

    // Count FIFO writes mid-cycle, away from the clock edge.
    always @(negedge Clk) begin
        if (bus_a.FIFOWrite) wr_a++;
        if (bus_b.FIFOWrite) wr_b++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        udata = b;
        uvld  = 1'b1;
        tick();
        uvld  = 1'b0;
    endtask

    task automatic do_reset();
        ResetN = 1'b0;
        tick();
        tick();
        ResetN = 1'b1;
        tick();
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_data",  bus_a.FIFOData,  32'h0);
        check("rst_write", bus_a.FIFOWrite, 32'h0);
        check("rst_busy",  bus_a.Busy,      32'h0);
        check("rst_ovf",   bus_a.Overflow,  32'h0);
        check("rst_tmo",   bus_a.Timeout,   32'h0);
        tick();
        ResetN = 1'b1;
        tick();

        // 1: spaced bytes, FIFO free
        snap = wr_a;
        send_byte(8'hDE);
        check("t1_busy_partial", bus_a.Busy, 32'h1);
        repeat (99) tick();
        send_byte(8'hAD);
        repeat (99) tick();
        send_byte(8'hBE);
        repeat (99) tick();
        check("t1_no_early_write", wr_a - snap, 32'h0);
        send_byte(8'hEF);
        check("t1_write", bus_a.FIFOWrite, 32'h1);
        check("t1_data",  bus_a.FIFOData,  32'hDEADBEEF);
        tick();
        check("t1_write_once", wr_a - snap, 32'h1);
        check("t1_idle_busy",  bus_a.Busy,  32'h0);

        // 2: FIFO full for 50 cycles after byte 4
        snap = wr_a;
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        ffull = 1'b1;
        send_byte(8'hEF);
        repeat (49) tick();
        check("t2_no_write_full", wr_a - snap, 32'h0);
        check("t2_busy_held",     bus_a.Busy,  32'h1);
        ffull = 1'b0;
        #1;
        check("t2_write", bus_a.FIFOWrite, 32'h1);
        check("t2_data",  bus_a.FIFOData,  32'hDEADBEEF);
        tick();
        check("t2_write_once", wr_a - snap,   32'h1);
        check("t2_no_timeout", bus_a.Timeout, 32'h0);

        // 3: byte dropped while full
        snap = wr_a;
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        ffull = 1'b1;
        send_byte(8'h04);
        send_byte(8'h55);
        check("t3_overflow",  bus_a.Overflow, 32'h1);
        check("t3_word_kept", bus_a.FIFOData, 32'h01020304);
        ffull = 1'b0;
        #1;
        check("t3_write", bus_a.FIFOWrite, 32'h1);
        check("t3_data",  bus_a.FIFOData,  32'h01020304);
        tick();
        send_byte(8'hA1);
        send_byte(8'hB2);
        send_byte(8'hC3);
        send_byte(8'hD4);
        check("t3_next_data", bus_a.FIFOData, 32'hA1B2C3D4);
        tick();
        check("t3_writes", wr_a - snap, 32'h2);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t3_ovf_cleared", bus_a.Overflow, 32'h0);

        // 4: byte coincides with an unblocked write
        snap = wr_a;
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        check("t4_write", bus_a.FIFOWrite, 32'h1);
        check("t4_data",  bus_a.FIFOData,  32'hAABBCCDD);
        send_byte(8'h11);
        check("t4_busy_next", bus_a.Busy,      32'h1);
        check("t4_no_write",  bus_a.FIFOWrite, 32'h0);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        check("t4_next_write", bus_a.FIFOWrite, 32'h1);
        check("t4_next_data",  bus_a.FIFOData,  32'h11223344);
        tick();
        check("t4_writes", wr_a - snap, 32'h2);

        // 5: idle timeout on the 20-cycle instance
        do_reset();
        snap = wr_b;
        send_byte(8'h12);
        send_byte(8'h34);
        repeat (19) tick();
        check("t5_no_timeout_yet", bus_b.Timeout, 32'h0);
        check("t5_busy_before",    bus_b.Busy,    32'h1);
        tick();
        check("t5_timeout", bus_b.Timeout,  32'h1);
        check("t5_busy",    bus_b.Busy,     32'h0);
        check("t5_shift",   bus_b.FIFOData, 32'h0);
        send_byte(8'hCA);
        send_byte(8'hFE);
        send_byte(8'hBA);
        send_byte(8'hBE);
        check("t5_write", bus_b.FIFOWrite, 32'h1);
        check("t5_data",  bus_b.FIFOData,  32'hCAFEBABE);
        tick();
        check("t5_writes", wr_b - snap, 32'h1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t5_tmo_cleared", bus_b.Timeout, 32'h0);
        // Byte on the expiry edge wins.
        send_byte(8'h01);
        repeat (19) tick();
        send_byte(8'h02);
        check("t5_byte_wins_tmo",  bus_b.Timeout, 32'h0);
        check("t5_byte_wins_busy", bus_b.Busy,    32'h1);

        // 6: asynchronous reset mid-word
        do_reset();
        snap = wr_a;
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        #2;
        ResetN = 1'b0;
        #1;
        check("t6_rst_busy", bus_a.Busy,     32'h0);
        check("t6_rst_data", bus_a.FIFOData, 32'h0);
        tick();
        ResetN = 1'b1;
        tick();
        send_byte(8'h0A);
        send_byte(8'h0B);
        send_byte(8'h0C);
        check("t6_no_early_write", wr_a - snap, 32'h0);
        send_byte(8'h0D);
        check("t6_write", bus_a.FIFOWrite, 32'h1);
        check("t6_data",  bus_a.FIFOData,  32'h0A0B0C0D);
        tick();
        check("t6_writes", wr_a - snap, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
